// File: rtl/matvec_pkg.sv
// Shared types and arithmetic helpers for the matrix-vector engine.
package matvec_pkg;

  typedef enum logic [1:0] {
    MV_PLAIN = 2'd0,
    MV_BIAS  = 2'd1,
    MV_INNOV = 2'd2,
    MV_RSVD  = 2'd3
  } mv_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_NORM = 2'd2,
    ST_HOLD = 2'd3
  } mv_state_t;

  // Widest accumulator / operand the rounding helper can handle.
  localparam int MAX_ACC_W  = 128;
  localparam int MAX_DATA_W = 64;

  // Full product width plus growth over COLS terms, plus headroom for the
  // bias term and the rounding constant, so the accumulator never wraps.
  function automatic int acc_width(input int data_width, input int cols);
    return 2 * data_width + $clog2(cols) + 2;
  endfunction

  // Round half-up, drop the fraction, clamp to the operand range.
  // Returns {sat, value}; value occupies the low data_width bits.
  function automatic logic [MAX_DATA_W:0] round_sat(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          data_width,
    input int                          frac_bits
  );
    logic signed [MAX_ACC_W-1:0] one;
    logic signed [MAX_ACC_W-1:0] r;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    logic [MAX_DATA_W:0]         res;
    one = 1;
    r   = acc;
    if (frac_bits > 0) r = r + (one <<< (frac_bits - 1));
    r   = r >>> frac_bits;
    hi  = (one <<< (data_width - 1)) - one;
    lo  = -(one <<< (data_width - 1));
    res = '0;
    if (r > hi) begin
      res[MAX_DATA_W]     = 1'b1;
      res[MAX_DATA_W-1:0] = hi[MAX_DATA_W-1:0];
    end else if (r < lo) begin
      res[MAX_DATA_W]     = 1'b1;
      res[MAX_DATA_W-1:0] = lo[MAX_DATA_W-1:0];
    end else begin
      res[MAX_DATA_W-1:0] = r[MAX_DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/matvec_engine_mac_lane.sv
// One row accumulator: load initial value, then add or subtract one
// full-precision signed product per enabled cycle.
module matvec_engine_mac_lane
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = 36
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  init,
  input  logic [ACC_W-1:0]      init_val,
  input  logic                  en,
  input  logic                  sub,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_W-1:0]      acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        prod_ext;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = ACC_W'(prod);

  // Accumulator register; clear wins over init, init over a MAC step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (clear) acc <= '0;
    else if (init)  acc <= init_val;
    else if (en)    acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
  end

endmodule

// File: rtl/matvec_engine.sv
// Signed fixed-point y = A*x / b + A*x / b - A*x, one column per cycle
// across ROWS parallel lanes, with round/saturate and held result.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// MAC     | accumulating column col into every lane
// NORM    | rounding/saturating accumulators into the output registers
// HOLD    | result valid, waiting for out_ready
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [1:0]                               mode,
  input  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mat,
  input  logic [COLS-1:0][DATA_WIDTH-1:0]          vec,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]          bias,
  input  logic                                     abort,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]          out,
  output logic [ROWS-1:0]                          out_sat,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     busy
);

  localparam int ACC_W = acc_width(DATA_WIDTH, COLS);
  localparam int CNT_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);

  mv_state_t state, state_nx;
  mv_mode_t  mode_q, mode_eff;

  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mat_q;
  logic [COLS-1:0][DATA_WIDTH-1:0]           vec_q;
  logic [CNT_W-1:0]                          col;
  logic                                      accept, mac_en, norm_en, last_col;
  logic [ROWS-1:0][DATA_WIDTH-1:0]           out_nx;
  logic [ROWS-1:0]                           sat_nx;

  // Reserved mode runs as plain so it never depends on bias.
  assign mode_eff = (mv_mode_t'(mode) == MV_RSVD) ? MV_PLAIN : mv_mode_t'(mode);
  assign last_col = (col == LAST_COL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) state_nx = ST_MAC;
        ST_MAC:  if (last_col) state_nx = ST_NORM;
        ST_NORM: state_nx = ST_HOLD;
        ST_HOLD: if (out_ready) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // FSM-decoded controls.
  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
    accept   = (state == ST_IDLE) && in_valid && !abort;
    mac_en   = (state == ST_MAC) && !abort;
    norm_en  = (state == ST_NORM) && !abort;
  end

  // Column counter restarts on every accepted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      col <= '0;
    else if (accept) col <= '0;
    else if (mac_en) col <= last_col ? '0 : col + 1'b1;
  end

  // Operand capture; inputs are free to change after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q  <= '0;
      vec_q  <= '0;
      mode_q <= MV_PLAIN;
    end else if (accept) begin
      mat_q  <= mat;
      vec_q  <= vec;
      mode_q <= mode_eff;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      init_val;
    logic [MAX_DATA_W:0]   rs;

    // Bias enters pre-scaled into the Q format of the products.
    assign init_val = (mode_eff == MV_PLAIN) ? '0
                    : (ACC_W'($signed(bias[r])) <<< FRAC_BITS);

    matvec_engine_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_W     (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (abort),
      .init    (accept),
      .init_val(init_val),
      .en      (mac_en),
      .sub     (mode_q == MV_INNOV),
      .a       (mat_q[r][col]),
      .b       (vec_q[col]),
      .acc     (acc)
    );

    assign rs         = round_sat(MAX_ACC_W'($signed(acc)), DATA_WIDTH, FRAC_BITS);
    assign out_nx[r]  = rs[DATA_WIDTH-1:0];
    assign sat_nx[r]  = rs[MAX_DATA_W];
  end

  // Result registers; held through HOLD, wiped by abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_sat   <= '0;
      out_valid <= 1'b0;
    end else if (abort) begin
      out       <= '0;
      out_sat   <= '0;
      out_valid <= 1'b0;
    end else if (norm_en) begin
      out       <= out_nx;
      out_sat   <= sat_nx;
      out_valid <= 1'b1;
    end else if ((state == ST_HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine with hand-computed Q8.8 results.
module tb_matvec_engine;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int R  = 4;
  localparam int C  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic abort = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic busy;
  logic [1:0] mode = 2'd0;
  logic [R-1:0][C-1:0][DW-1:0] mat = '0;
  logic [C-1:0][DW-1:0] vec = '0;
  logic [R-1:0][DW-1:0] bias = '0;
  logic [R-1:0][DW-1:0] out;
  logic [R-1:0] out_sat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  matvec_engine #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB),
    .ROWS      (R),
    .COLS      (C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .mat      (mat),
    .vec      (vec),
    .bias     (bias),
    .abort    (abort),
    .out      (out),
    .out_sat  (out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [R-1:0][C-1:0][DW-1:0] diag(input logic [DW-1:0] d);
    logic [R-1:0][C-1:0][DW-1:0] m;
    m = '0;
    for (int i = 0; i < R; i++) m[i][i] = d;
    return m;
  endfunction

  function automatic logic [R-1:0][C-1:0][DW-1:0] fill_mat(input logic [DW-1:0] d);
    logic [R-1:0][C-1:0][DW-1:0] m;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) m[i][j] = d;
    return m;
  endfunction

  function automatic logic [C-1:0][DW-1:0] fill_vec(input logic [DW-1:0] d);
    logic [C-1:0][DW-1:0] v;
    for (int j = 0; j < C; j++) v[j] = d;
    return v;
  endfunction

  // Drive operands, let one edge accept them, return just after it.
  task automatic issue(input string tag, input logic [1:0] m,
                       input logic [R-1:0][C-1:0][DW-1:0] a,
                       input logic [C-1:0][DW-1:0] x,
                       input logic [R-1:0][DW-1:0] b);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    mode = m; mat = a; vec = x; bias = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
  endtask

  task automatic op(input string tag, input logic [1:0] m,
                    input logic [R-1:0][C-1:0][DW-1:0] a,
                    input logic [C-1:0][DW-1:0] x,
                    input logic [R-1:0][DW-1:0] b,
                    input logic [63:0] exp_out, input logic [3:0] exp_sat);
    int lat;
    issue(tag, m, a, x, b);
    wait_result(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk({tag, "_out"}, 64'(out), exp_out);
    chk({tag, "_sat"}, 64'(out_sat), 64'(exp_sat));
    consume(tag);
  endtask

  logic [C-1:0][DW-1:0] vec_a;
  logic [R-1:0][C-1:0][DW-1:0] m1;
  logic [C-1:0][DW-1:0] v1;
  logic [63:0] held;
  logic seen;
  int lat;

  initial begin
    vec_a = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};

    // reset values
    #1;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sat", 64'(out_sat), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // identity pass-through
    op("ident", 2'd0, diag(16'h0100), vec_a, '0, 64'h0080_FF00_0200_0100, 4'b0000);

    // bias modes
    op("innov", 2'd2, diag(16'h0100), fill_vec(16'h0100), {4{16'h0300}},
       {4{16'h0200}}, 4'b0000);
    op("bias", 2'd1, diag(16'h0100), fill_vec(16'h0100), {4{16'h0300}},
       {4{16'h0400}}, 4'b0000);
    op("rsvd", 2'd3, diag(16'h0100), fill_vec(16'h0100), {4{16'h0300}},
       {4{16'h0100}}, 4'b0000);

    // saturation
    op("sat_pos", 2'd0, fill_mat(16'h7FFF), fill_vec(16'h7FFF), '0,
       {4{16'h7FFF}}, 4'b1111);
    op("sat_neg", 2'd0, fill_mat(16'h7FFF), fill_vec(16'h8000), '0,
       {4{16'h8000}}, 4'b1111);

    // rounding around the half-LSB point
    m1 = '0; m1[0][0] = 16'h0001;
    v1 = '0; v1[0] = 16'h0080;
    op("rnd_half", 2'd0, m1, v1, '0, 64'h0000_0000_0000_0001, 4'b0000);
    v1[0] = 16'h007F;
    op("rnd_below", 2'd0, m1, v1, '0, 64'h0000_0000_0000_0000, 4'b0000);
    m1[0][0] = 16'hFFFF;
    v1[0] = 16'h0081;
    op("rnd_neg", 2'd0, m1, v1, '0, 64'h0000_0000_0000_FFFF, 4'b0000);

    // isolation and backpressure: operands change after accept, second request ignored
    issue("bp", 2'd0, diag(16'h0100), vec_a, '0);
    mat = fill_mat(16'h7FFF); vec = fill_vec(16'h1234);
    wait_result(lat);
    chk("bp_lat", 64'(lat), 64'd5);
    chk("iso_out", 64'(out), 64'h0080_FF00_0200_0100);
    held = 64'(out);
    in_valid = 1'b1; mode = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out", 64'(out), held);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", 64'(out_valid), 64'd0);
    chk("bp_idle", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("bp_no_second", 64'(busy), 64'd0);

    // abort during MAC
    issue("abort", 2'd0, diag(16'h0100), vec_a, '0);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_out", 64'(out), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);

    // abort wins over in_valid in IDLE
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_no_accept", 64'(busy), 64'd0);
    op("after_abort", 2'd2, diag(16'h0100), fill_vec(16'h0100), {4{16'h0300}},
       {4{16'h0200}}, 4'b0000);

    // async reset while holding a result
    issue("rst_hold", 2'd0, diag(16'h0100), vec_a, '0);
    wait_result(lat);
    chk("rst_hold_valid_before", 64'(out_valid), 64'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 64'(out_valid), 64'd0);
    chk("rst_hold_out", 64'(out), 64'd0);
    chk("rst_hold_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op("after_rst", 2'd1, diag(16'h0100), fill_vec(16'h0100), {4{16'h0300}},
       {4{16'h0400}}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Parametrised signed fixed-point matrix-vector engine for the EdgeAccel sensor-fusion datapath. It computes y = A·x, y = b + A·x or y = b − A·x for a ROWS×COLS matrix. It runs one column per cycle across ROWS parallel MAC lanes, then rounds and saturates to the operand format. Operands are captured on a valid/ready handshake. Results are held under output backpressure. It is the generalised successor of the fixed 2×2 unsigned multiplier and serves Kalman predict/innovation steps.

## Interface
- DATA_WIDTH, 16, operand/result width, signed two's complement
- FRAC_BITS, 8, fractional bits of the Q format (0 ≤ FRAC_BITS < DATA_WIDTH)
- ROWS, 4, matrix rows = output length (≥1)
- COLS, 4, matrix columns = vector length (≥1)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  operands and mode valid
- in_ready  out  1  engine can accept (high only in IDLE)
- mode  in  2  0 MV_PLAIN y=A·x, 1 MV_BIAS y=b+A·x, 2 MV_INNOV y=b−A·x, 3 reserved (executes as MV_PLAIN)
- mat  in  [ROWS][COLS]×DATA_WIDTH  matrix A
- vec  in  [COLS]×DATA_WIDTH  vector x
- bias  in  [ROWS]×DATA_WIDTH  vector b (ignored in MV_PLAIN)
- abort  in  1  synchronous cancel
- out  out  [ROWS]×DATA_WIDTH  result y, registered
- out_sat  out  ROWS  per-row saturation flag for the current result
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, MAC, NORM, HOLD.
  - IDLE → MAC on in_valid && in_ready. That edge latches mat, vec, bias and mode into internal registers.
  - MAC runs COLS cycles using column counter c = 0..COLS−1. On the last column it moves to NORM.
  - NORM lasts 1 cycle. It writes out/out_sat, sets out_valid and moves to HOLD.
  - HOLD → IDLE on out_ready. out_valid clears on the same edge.
- Accumulator width: ACC_W = 2·DATA_WIDTH + $clog2(COLS) + 2. Internal overflow is impossible.
- Accumulator init, on the accept edge:
  - MV_PLAIN: 0.
  - Other modes: sign-extended bias[r] << FRAC_BITS.
- MAC step, per lane r: acc[r] ± sext(mat[r][c]) · sext(vec[c]).
  - Sign is − in MV_INNOV and + otherwise.
  - Full-precision product.
- NORM step:
  - Round half-up: add 2^(FRAC_BITS−1), skipped when FRAC_BITS=0.
  - Arithmetic shift right by FRAC_BITS.
  - Clamp to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. out_sat[r]=1 iff clamping occurred.
- Operand inputs are don't-care after the accept edge.
- in_valid outside IDLE is ignored (in_ready=0).
- abort:
  - In any state, → IDLE on the next edge.
  - Clears out_valid, out and out_sat.
  - Has priority over out_ready and in_valid on the same edge.
  - abort && in_valid in IDLE: no accept.
- Async reset mid-operation: immediate IDLE, outputs at reset values, no partial result ever appears.

## Timing
- Reset values:
  - out = 0, out_sat = 0, out_valid = 0, busy = 0.
  - in_ready = 1 (combinational from state IDLE).
- Latency: out_valid rises COLS+1 cycles after the accept edge (5 for defaults).
- Throughput: with out_ready tied high, one operation every COLS+3 cycles.
- Hold stability: out and out_sat are stable while out_valid=1 and out_ready=0.
- Back-to-back accept: the next accept is possible on the cycle after HOLD exits.

## Structure
- Package matvec_pkg holds:
  - mv_mode_t enum: MV_PLAIN, MV_BIAS, MV_INNOV, MV_RSVD.
  - mv_state_t enum.
  - Function acc_width(DATA_WIDTH, COLS).
  - Function round_sat(acc) returning {sat, value}.
- Sub-module mac_lane: one row's accumulator, with init, add/sub MAC and clear inputs. ROWS instances are generated.
- The top holds the FSM, column counter, operand registers and output registers.

## Test plan
- Identity and pass-through: defaults, MV_PLAIN, A = diag 0x0100, x = {0x0100, 0x0200, 0xFF00, 0x0080} → out = x, out_sat = 0, out_valid exactly 5 cycles after accept.
- Innovation mode: MV_INNOV, A = identity, x = all 0x0100, b = all 0x0300 → out = all 0x0200. Same operands with MV_BIAS → all 0x0400. mode=3 → all 0x0100.
- Saturation:
  - A = all 0x7FFF, x = all 0x7FFF → out = all 0x7FFF, out_sat = 4'b1111.
  - x = all 0x8000 → out = all 0x8000, out_sat = 4'b1111.
- Rounding, only A[0][0] nonzero:
  - A[0][0] = 0x0001, x[0] = 0x0080 → out[0] = 0x0001.
  - x[0] = 0x007F → 0x0000.
  - A[0][0] = 0xFFFF, x[0] = 0x0081 → 0xFFFF.
- Backpressure and isolation:
  - Hold out_ready=0 for 10 cycles → out and out_valid stable, in_ready=0, a second in_valid is not accepted.
  - Changing mat/vec after accept leaves the result unchanged.
- Abort and reset:
  - abort at MAC cycle 2 → IDLE next edge, out = 0, out_valid never rises.
  - rst_n pulsed during HOLD → out_valid drops immediately.
  - The following operation is correct in both cases.
